// File: rtl/stream_demux.sv
// Registered 1-to-CHANNELS stream demultiplexer with valid/ready on every side.
// Optional broadcast path enabled by defining DEMUX_BCAST_EN.
module stream_demux #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      bcast,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      sel_err
);

  logic [CHANNELS-1:0]       out_valid_q, out_valid_d;
  logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
  logic                      sel_err_q, sel_err_d;

  logic [CHANNELS-1:0] slot_free;
  logic [CHANNELS-1:0] sel_hit;
  logic                sel_ok;
  logic                sel_free;
  logic                bcast_req;
  logic                xfer;

`ifdef DEMUX_BCAST_EN
  assign bcast_req = bcast;
`else
  logic unused_bcast;
  assign unused_bcast = bcast;
  assign bcast_req    = 1'b0;
`endif

  // A slot can take a word when empty or when its current word leaves this cycle.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (int'(in_sel) == k);
    end
    slot_free = ~out_valid_q | out_ready;
    sel_ok    = |sel_hit;
    sel_free  = |(slot_free & sel_hit);
  end

  // Out-of-range selects are always accepted so they can be dropped and flagged.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (bcast_req) begin
        in_ready = &slot_free;
      end else if (sel_ok) begin
        in_ready = sel_free;
      end else begin
        in_ready = 1'b1;
      end
    end
  end

  assign xfer = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    sel_err_d   = sel_err_q;
    if (xfer) begin
      if (bcast_req) begin
        out_valid_d = '1;
        for (int k = 0; k < CHANNELS; k++) begin
          out_data_d[k*WIDTH +: WIDTH] = in_data;
        end
      end else if (!sel_ok) begin
        sel_err_d = 1'b1;
      end else begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (sel_hit[k]) begin
            out_valid_d[k]               = 1'b1;
            out_data_d[k*WIDTH +: WIDTH] = in_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: per-channel expected-word queues filled by
// the driver, drained and compared by an independent monitor.
module tb_stream_demux;

  localparam int W = 16;
  localparam int C = 4;
`ifdef DEMUX_BCAST_EN
  localparam bit BCAST_ON = 1'b1;
`else
  localparam bit BCAST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]   in_data = '0;
  logic [1:0]     in_sel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           bcast = 1'b0;
  logic [C*W-1:0] out_data;
  logic [C-1:0]   out_valid;
  logic [C-1:0]   out_ready = '1;
  logic           sel_err;

  logic [W-1:0]   in_data3 = '0;
  logic [1:0]     in_sel3 = '0;
  logic           in_valid3 = 1'b0;
  logic           in_ready3;
  logic           bcast3 = 1'b0;
  logic [3*W-1:0] out_data3;
  logic [2:0]     out_valid3;
  logic [2:0]     out_ready3 = '1;
  logic           sel_err3;

  stream_demux #(.WIDTH(W), .CHANNELS(C)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .bcast(bcast), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  stream_demux #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .bcast(bcast3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .sel_err(sel_err3)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [C][$];
  logic [W-1:0] last_data [C];
  logic [C-1:0] pushed_now = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // A channel holds at most one undelivered word; it accepts when empty or draining.
  function automatic bit modelReady(input logic [1:0] s, input bit b, input logic [C-1:0] r);
    bit ok;
    if (BCAST_ON && b) begin
      ok = 1'b1;
      for (int k = 0; k < C; k++) ok = ok && (exp_q[k].size() == 0 || r[k]);
      return ok;
    end
    return exp_q[s].size() == 0 || r[s];
  endfunction

  task automatic applyStimulus(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                               input bit b, input logic [C-1:0] r);
    bit exp_ready;
    @(posedge clk);
    #1;
    pushed_now = '0;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    bcast      = b;
    out_ready  = r;
    #1;
    exp_ready = modelReady(s, b, r);
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    if (v && exp_ready) begin
      if (BCAST_ON && b) begin
        for (int k = 0; k < C; k++) exp_q[k].push_back(d);
        pushed_now = '1;
      end else begin
        exp_q[s].push_back(d);
        pushed_now[s] = 1'b1;
      end
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid3  = 1'b0;
    bcast      = 1'b0;
    in_sel     = '0;
    pushed_now = '0;
    for (int k = 0; k < C; k++) begin
      exp_q[k].delete();
      last_data[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("reset out_valid", {60'd0, out_valid}, 64'd0);
    checkOutput("reset out_data", out_data, 64'd0);
    checkOutput("reset sel_err", {63'd0, sel_err}, 64'd0);
    checkOutput("reset sel_err3", {63'd0, sel_err3}, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  // Monitor: sampled mid-cycle, when this cycle's inputs are stable before the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < C; k++) begin
        bit ev;
        ev = (exp_q[k].size() - int'(pushed_now[k])) > 0;
        checkOutput($sformatf("out_valid[%0d]", k), {63'd0, out_valid[k]}, {63'd0, ev});
        if (ev) begin
          checkOutput($sformatf("out_data[%0d]", k), {48'd0, out_data[k*W +: W]},
                      {48'd0, exp_q[k][0]});
          if (out_ready[k]) last_data[k] = exp_q[k].pop_front();
        end else begin
          checkOutput($sformatf("held out_data[%0d]", k), {48'd0, out_data[k*W +: W]},
                      {48'd0, last_data[k]});
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < C; k++) last_data[k] = '0;
    doReset();

    applyStimulus(1'b1, 2'd2, 16'hA5A5, 1'b0, 4'b1111);
    repeat (3) applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 4'b1111);

    applyStimulus(1'b1, 2'd1, 16'h0001, 1'b0, 4'b1101);
    applyStimulus(1'b1, 2'd1, 16'h0002, 1'b0, 4'b1101);
    applyStimulus(1'b1, 2'd0, 16'h0003, 1'b0, 4'b1101);
    applyStimulus(1'b1, 2'd1, 16'h0002, 1'b0, 4'b1111);
    repeat (2) applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 4'b1111);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'd3, 16'h3000 + 16'(i), 1'b0, 4'b1111);
    end
    repeat (2) applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 4'b1111);

    applyStimulus(1'b1, 2'd0, 16'h00AA, 1'b0, 4'b1110);
    applyStimulus(1'b1, 2'd0, 16'h1234, 1'b1, 4'b1110);
    applyStimulus(1'b1, 2'd0, 16'h1234, 1'b1, 4'b1111);
    repeat (2) applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 4'b1111);

    @(posedge clk);
    #1;
    in_valid3 = 1'b1;
    in_sel3   = 2'd3;
    in_data3  = 16'hBEEF;
    #1;
    checkOutput("ch3dut in_ready bad sel", {63'd0, in_ready3}, 64'd1);
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    #1;
    checkOutput("ch3dut out_valid after drop", {61'd0, out_valid3}, 64'd0);
    checkOutput("ch3dut sel_err set", {63'd0, sel_err3}, 64'd1);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("ch3dut sel_err sticky", {63'd0, sel_err3}, 64'd1);
    in_valid3 = 1'b1;
    in_sel3   = 2'd1;
    in_data3  = 16'h5A5A;
    #1;
    checkOutput("ch3dut in_ready good sel", {63'd0, in_ready3}, 64'd1);
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    #1;
    checkOutput("ch3dut out_valid", {61'd0, out_valid3}, 64'd2);
    checkOutput("ch3dut out_data[1]", {48'd0, out_data3[W +: W]}, 64'h5A5A);

    doReset();

    for (int i = 0; i < 400; i++) begin
      logic [C-1:0] r;
      r = 4'($urandom) | 4'($urandom);
      applyStimulus(($urandom % 4) != 0, 2'($urandom), 16'($urandom),
                    ($urandom % 8) == 0, r);
      if (i == 200) doReset();
    end
    repeat (3) applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 4'b1111);

    checkOutput("main sel_err never set", {63'd0, sel_err}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
